// File: rtl/debug_frame_rx.sv
// Host-side 8N1 UART receiver that reassembles DATA_WIDTH-bit words (first byte = MSB).
// Optional even-parity frame support is enabled by defining DEBUG_RX_PARITY_EN.
module debug_frame_rx #(
    parameter int DIVIDER_TICKS_WIDTH = 10,
    parameter int DIVIDER_TICKS       = 1023,
    parameter int DATA_WIDTH          = 24,
    parameter int TIMEOUT_BITS        = 32
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  rx_in,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  timeout
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int COUNT_W        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * DIVIDER_TICKS;
    localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DIVIDER_TICKS_WIDTH-1:0] TICK_HALF = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS / 2);
    localparam logic [DIVIDER_TICKS_WIDTH-1:0] TICK_LAST = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
    localparam logic [COUNT_W-1:0]             COUNT_LAST = COUNT_W'(BYTES_PER_WORD - 1);
    localparam logic [IDLE_W-1:0]              IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
`ifdef DEBUG_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t state, state_next;

    logic [1:0]                     sync_q;
    logic                           rx_s;
    logic                           rx_prev;
    logic                           fall;
    logic [DIVIDER_TICKS_WIDTH-1:0] tick;
    logic [2:0]                     bit_cnt;
    logic [7:0]                     shift_reg;
    logic [COUNT_W-1:0]             byte_count;
    logic [IDLE_W-1:0]              idle_cnt;
    logic [DATA_WIDTH-1:0]          full_word;

    logic timing_active;
    logic mid_bit;
    logic data_sample;
    logic byte_good;
    logic frame_bad;
    logic timeout_hit;

    // Sync flops preset to 1 so reset looks like an idle line and never fakes a start edge.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts by one stage per clock.
            sync_q  <= {sync_q[0], rx_in};
            rx_prev <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];
    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: defaulting to the current state first means no path leaves state_next unassigned, so no latch.
        state_next = state;
        unique case (state)
            IDLE:      if (fall) state_next = START;
            START:     if (tick == TICK_HALF) state_next = rx_s ? IDLE : DATA;
`ifdef DEBUG_RX_PARITY_EN
            DATA:      if (mid_bit && bit_cnt == 3'd7) state_next = PARITY;
            PARITY:    if (mid_bit) state_next = (rx_s == ^shift_reg) ? STOP : WAIT_HIGH;
`else
            DATA:      if (mid_bit && bit_cnt == 3'd7) state_next = STOP;
`endif
            STOP:      if (mid_bit) state_next = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        timing_active = (state == START) || (state == DATA) || (state == STOP);
        frame_bad     = (state == STOP) && mid_bit && !rx_s;
`ifdef DEBUG_RX_PARITY_EN
        timing_active = timing_active || (state == PARITY);
        frame_bad     = frame_bad || ((state == PARITY) && mid_bit && (rx_s != ^shift_reg));
`endif
        data_sample   = (state == DATA) && mid_bit;
        byte_good     = (state == STOP) && mid_bit && rx_s;
        timeout_hit   = (state == IDLE) && (byte_count != '0) && (idle_cnt == IDLE_LAST);
    end

    assign mid_bit = (tick == TICK_LAST);

    // Bit timer restarts on every state change and on each mid-bit sample.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tick      <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (!timing_active || state_next != state || mid_bit) tick <= '0;
            else                                                  tick <= tick + 1'b1;

            if (state != DATA)    bit_cnt <= '0;
            else if (data_sample) bit_cnt <= bit_cnt + 1'b1;

            if (data_sample) shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

    generate
        if (DATA_WIDTH > 8) begin : g_multi_byte
            logic [DATA_WIDTH-9:0] partial;

            assign full_word = {partial, shift_reg};

            always_ff @(posedge clk_in or negedge reset) begin
                if (!reset)         partial <= '0;
                else if (byte_good) partial <= full_word[DATA_WIDTH-9:0];
            end
        end else begin : g_single_byte
            assign full_word = shift_reg;
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
            byte_count  <= '0;
        end else begin
            byte_valid  <= 1'b0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
            if (byte_good) begin
                byte_out   <= shift_reg;
                byte_valid <= 1'b1;
                if (byte_count == COUNT_LAST) begin
                    data_out   <= full_word;
                    data_valid <= 1'b1;
                    byte_count <= '0;
                end else begin
                    byte_count <= byte_count + 1'b1;
                end
            end else if (frame_bad) begin
                frame_error <= 1'b1;
                byte_count  <= '0;
            end else if (timeout_hit) begin
                timeout    <= 1'b1;
                byte_count <= '0;
            end
        end
    end

    // Idle timer only runs while a partial word is pending in IDLE.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)                                               idle_cnt <= '0;
        else if (state != IDLE || byte_count == '0 || timeout_hit) idle_cnt <= '0;
        else                                                      idle_cnt <= idle_cnt + 1'b1;
    end

endmodule

// File: tb/tb_debug_frame_rx.sv
// Directed bench for debug_frame_rx: word table plus glitch, framing, timeout and reset sequences.
// Define DEBUG_RX_PARITY_EN for both bench and RTL to exercise the parity frame.
module tb_debug_frame_rx;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [23:0] data_out;
    logic        data_valid;
    logic        frame_error;
    logic        timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    int n_byte = 0, n_data = 0, n_ferr = 0, n_tout = 0, n_overlap = 0;

    always #5 clk = ~clk;

    debug_frame_rx #(
        .DIVIDER_TICKS_WIDTH(10),
        .DIVIDER_TICKS      (DIV),
        .DATA_WIDTH         (24),
        .TIMEOUT_BITS       (32)
    ) dut (
        .clk_in     (clk),
        .reset      (rst_n),
        .rx_in      (rx),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .timeout    (timeout)
    );

    // Pulse counters; a pulse held for two cycles would be counted twice.
    always @(negedge clk) begin
        if (byte_valid)  n_byte <= n_byte + 1;
        if (data_valid)  n_data <= n_data + 1;
        if (frame_error) n_ferr <= n_ferr + 1;
        if (timeout)     n_tout <= n_tout + 1;
        if ((data_valid && !byte_valid) || (data_valid && (frame_error || timeout)))
            n_overlap <= n_overlap + 1;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] word;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef DEBUG_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_bit);
    endtask

`ifdef DEBUG_RX_PARITY_EN
    task automatic send_byte_par(input logic [7:0] b, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
    endtask

    int sb, sd, sf, st;

    task automatic snap();
        sb = n_byte; sd = n_data; sf = n_ferr; st = n_tout;
    endtask

    initial begin
        vecs[0] = '{8'hF0, 8'hAA, 8'h0D, 24'hF0AA0D};
        vecs[1] = '{8'h00, 8'hFF, 8'h80, 24'h00FF80};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
        vecs[3] = '{8'h5A, 8'hA5, 8'h3C, 24'h5AA53C};

        rx    = 1'b1;
        rst_n = 1'b0;
        settle(3);
        check("reset byte_out",    32'(byte_out),    32'h0);
        check("reset byte_valid",  32'(byte_valid),  32'h0);
        check("reset data_out",    32'(data_out),    32'h0);
        check("reset data_valid",  32'(data_valid),  32'h0);
        check("reset frame_error", 32'(frame_error), 32'h0);
        check("reset timeout",     32'(timeout),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(10);

        // Back-to-back words from the table.
        for (int v = 0; v < 4; v++) begin
            snap();
            send_word(vecs[v].b0, vecs[v].b1, vecs[v].b2);
            settle(8);
            check($sformatf("vec%0d byte_valid count", v), 32'(n_byte - sb), 32'd3);
            check($sformatf("vec%0d data_valid count", v), 32'(n_data - sd), 32'd1);
            check($sformatf("vec%0d data_out", v),         32'(data_out),    32'(vecs[v].word));
            check($sformatf("vec%0d byte_out", v),         32'(byte_out),    32'(vecs[v].b2));
            check($sformatf("vec%0d frame_error count", v), 32'(n_ferr - sf), 32'd0);
        end

        // Short low glitch: START must abort silently.
        snap();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        settle(3 * DIV);
        check("glitch byte_valid count",  32'(n_byte - sb), 32'd0);
        check("glitch frame_error count", 32'(n_ferr - sf), 32'd0);

        // Bad stop bit, then a clean word with no stale bytes mixed in.
        snap();
        send_byte(8'h55, 1'b0);
        rx = 1'b1;
        settle(20);
        check("badstop frame_error count", 32'(n_ferr - sf), 32'd1);
        check("badstop byte_valid count",  32'(n_byte - sb), 32'd0);
        check("badstop data_out held",     32'(data_out),    32'h5AA53C);
        snap();
        send_word(8'h11, 8'h22, 8'h33);
        settle(8);
        check("after badstop data_out",   32'(data_out),    32'h112233);
        check("after badstop data_valid", 32'(n_data - sd), 32'd1);

        // Gap shorter than the timeout keeps the partial word.
        snap();
        send_byte(8'h12, 1'b1);
        settle(400);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        settle(8);
        check("short gap timeout count", 32'(n_tout - st), 32'd0);
        check("short gap data_out",      32'(data_out),    32'h123456);

        // Long gap discards the partial word.
        snap();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        settle(600);
        check("timeout pulse count",      32'(n_tout - st), 32'd1);
        check("timeout data_valid count", 32'(n_data - sd), 32'd0);
        check("timeout data_out held",    32'(data_out),    32'h123456);
        snap();
        send_word(8'hAB, 8'hCD, 8'hEF);
        settle(8);
        check("after timeout data_out",   32'(data_out),    32'hABCDEF);
        check("after timeout data_valid", 32'(n_data - sd), 32'd1);

        // Reset in the middle of the second byte of a word.
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset data_out", 32'(data_out), 32'h0);
        check("midreset byte_out", 32'(byte_out), 32'h0);
        rx = 1'b1;
        settle(3);
        @(negedge clk);
        rst_n = 1'b1;
        settle(5);
        snap();
        send_word(8'h01, 8'h02, 8'h03);
        settle(8);
        check("after reset data_out",   32'(data_out),    32'h010203);
        check("after reset data_valid", 32'(n_data - sd), 32'd1);

`ifdef DEBUG_RX_PARITY_EN
        snap();
        send_byte_par(8'h03, 1'b0);
        settle(8);
        check("parity ok byte_valid",  32'(n_byte - sb), 32'd1);
        check("parity ok frame_error", 32'(n_ferr - sf), 32'd0);
        check("parity ok byte_out",    32'(byte_out),    32'h03);
        snap();
        send_byte_par(8'h03, 1'b1);
        settle(8);
        check("parity bad frame_error", 32'(n_ferr - sf), 32'd1);
        check("parity bad byte_valid",  32'(n_byte - sb), 32'd0);
`endif

        check("data_valid overlap count", 32'(n_overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
